// File: rtl/vga_fb_writer.sv
// rtl/vga_fb_writer.sv - pixel FIFO and frame-buffer write port with screen clear
//
// Buffers the drawers' pixel-write stream in a small FIFO, converts each
// pixel to a linear address (y*320+x) and drives the 320x240x3 frame-buffer
// write port. After reset, or when iClear is pulsed, it sweeps the whole
// buffer with BG_COLOUR before draining pixels again.
//
// Ports:
//   iClock      system clock, rising edge
//   iReset      asynchronous active-high reset
//   iX, iY      pixel coordinate (9 / 8 bits)
//   iColour     pixel colour (3 bits)
//   iPlot       pixel strobe, one pixel per high cycle
//   iClear      single-cycle clear-screen request
//   oReady      FIFO has room this cycle
//   oBusy       clear sweep in progress
//   oMemAddr    frame-buffer write address (17 bits)
//   oMemData    frame-buffer write data (3 bits)
//   oMemWe      frame-buffer write enable
//   oDropCount  saturating count of rejected pixels (8 bits)

module vga_fb_writer #(
  parameter int         X_SCREEN_PIXELS = 320,
  parameter int         Y_SCREEN_PIXELS = 240,
  parameter int         FIFO_DEPTH      = 4,
  parameter logic [2:0] BG_COLOUR       = 3'b000
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [8:0]  iX,
  input  logic [7:0]  iY,
  input  logic [2:0]  iColour,
  input  logic        iPlot,
  input  logic        iClear,
  output logic        oReady,
  output logic        oBusy,
  output logic [16:0] oMemAddr,
  output logic [2:0]  oMemData,
  output logic        oMemWe,
  output logic [7:0]  oDropCount
);

  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = PW + 1;
  localparam logic [16:0] LAST_ADDR = 17'(X_SCREEN_PIXELS * Y_SCREEN_PIXELS - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t        state;
  logic [16:0]   clr_cnt;
  logic [19:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          in_range;
  logic          accept;
  logic          pop;
  logic [16:0]   push_addr;

  assign oReady   = (count < CW'(FIFO_DEPTH));
  assign oBusy    = (state == S_CLEAR);
  assign in_range = ({1'b0, iX} < 10'(X_SCREEN_PIXELS)) &&
                    ({1'b0, iY} < 9'(Y_SCREEN_PIXELS));
  assign accept   = iPlot && oReady && !iClear && in_range;
  // A clear flushes the FIFO, so nothing is popped on the clearing edge.
  assign pop      = (state == S_RUN) && (count != '0) && !iClear;
  // y*320 + x as y*256 + y*64 + x; max 76799 fits in 17 bits.
  assign push_addr = {1'b0, iY, 8'b0} + {3'b0, iY, 6'b0} + {8'b0, iX};

  always_ff @(posedge iClock) begin
    if (accept) begin
      fifo_mem[wr_ptr] <= {push_addr, iColour};
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state      <= S_CLEAR;
      clr_cnt    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      oMemAddr   <= '0;
      oMemData   <= '0;
      oMemWe     <= 1'b0;
      oDropCount <= '0;
    end else begin
      if (iPlot && !accept && (oDropCount != 8'hFF)) begin
        oDropCount <= oDropCount + 8'd1;
      end

      if (iClear) begin
        // Restart the sweep from address 0 and discard pending pixels.
        state   <= S_CLEAR;
        clr_cnt <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        oMemWe  <= 1'b0;
      end else begin
        if (accept) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (accept && !pop) begin
          count <= count + CW'(1);
        end else if (!accept && pop) begin
          count <= count - CW'(1);
        end

        case (state)
          S_CLEAR: begin
            oMemAddr <= clr_cnt;
            oMemData <= BG_COLOUR;
            oMemWe   <= 1'b1;
            clr_cnt  <= clr_cnt + 17'd1;
            if (clr_cnt == LAST_ADDR) begin
              state <= S_RUN;
            end
          end
          default: begin
            if (pop) begin
              oMemAddr <= fifo_mem[rd_ptr][19:3];
              oMemData <= fifo_mem[rd_ptr][2:0];
              oMemWe   <= 1'b1;
            end else begin
              oMemWe   <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/vga_fb_writer.md
# vga_fb_writer

Pixel sink for the synth's VGA display path. It consumes the pixel-write stream (X, Y, colour, plot strobe) produced by the display drawers and buffers it in a small FIFO. It converts each pixel to a linear frame-buffer address and drives the write port of the 320x240x3-bit frame-buffer RAM. After reset, or on request, it also clears the whole screen to a background colour.

## Interface
Parameters:
- X_SCREEN_PIXELS, 320, visible width; valid x is 0..319
- Y_SCREEN_PIXELS, 240, visible height; valid y is 0..239
- FIFO_DEPTH, 4, pixel FIFO entries (power of two, minimum 2)
- BG_COLOUR, 3'b000, colour written during a clear

Ports:
- iClock  in  1  system clock; all state on rising edge
- iReset  in  1  asynchronous, active-high reset
- iX  in  9  pixel x coordinate
- iY  in  8  pixel y coordinate
- iColour  in  3  pixel colour
- iPlot  in  1  pixel-write strobe; one pixel per high cycle
- iClear  in  1  single-cycle request to clear the screen
- oReady  out  1  FIFO can accept a pixel this cycle
- oBusy  out  1  clear sweep in progress
- oMemAddr  out  17  frame-buffer write address, y*320+x
- oMemData  out  3  frame-buffer write data
- oMemWe  out  1  frame-buffer write enable
- oDropCount  out  8  saturating count of rejected pixels

## Operation
- FSM states: CLEAR and RUN. Reset enters CLEAR with the clear counter at 0.
- CLEAR, on each edge:
  - oMemAddr <= clr_cnt, oMemData <= BG_COLOUR, oMemWe <= 1, then clr_cnt increments.
  - The edge that issues address 76799 moves the FSM to RUN.
  - The FIFO does not drain in CLEAR.
- RUN: if the FIFO is non-empty, pop one entry per edge and register its address, colour and oMemWe=1. Otherwise register oMemWe=0.
- Accept rule: a pixel is accepted when iPlot=1, oReady=1, iClear=0, iX<320 and iY<240.
  - oReady = (FIFO count < FIFO_DEPTH), from the registered count only. A pop in the same cycle does not free a slot.
  - Accepted entries hold {address, colour}. The address is computed at accept time as (iY<<8)+(iY<<6)+iX, 17 bits, with no truncation.
- Drop rule: iPlot=1 with any accept condition false increments oDropCount by 1, saturating at 255. Out-of-range coordinates are never written.
- iClear:
  - Flushes the FIFO (count := 0). Flushed entries are not counted as drops.
  - Sets clr_cnt := 0 and enters or re-enters CLEAR, including when a clear is already in progress (the sweep restarts).
  - An iPlot in the same cycle as iClear is dropped and counted.
- Order: pixels reach the memory port in acceptance order. No pixel is ever written twice.
- Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged.

## Timing
- Reset values:
  - oMemWe=0, oMemAddr=0, oMemData=0, oDropCount=0
  - oBusy=1 (state CLEAR), oReady=1 (FIFO empty)
- Clear sweep:
  - Occupies the first 76800 edges after reset deassertion, one write per edge, addresses 0..76799 ascending.
  - oBusy falls with the edge that issues address 76799.
  - oMemWe stays high for all 76800 cycles.
- Pixel latency:
  - A pixel accepted on edge k, with the FIFO empty and state RUN, drives oMemWe/oMemAddr/oMemData after edge k+1.
  - Throughput is 1 pixel/cycle, so continuous plotting in RUN never fills the FIFO.
- oDropCount updates on the edge that samples the rejected strobe.
- Reset asserted mid-operation immediately forces all reset values, empties the FIFO and restarts the full clear sweep on release.

## Test plan
- Reset release → exactly 76800 writes, addresses 0..76799, data 000. Then oBusy=0, oMemWe=0 and oDropCount=0.
- After clear, plot (66,124,3'b110) for one cycle → one write of addr 39746, data 110, visible after the second edge. oMemWe is high for exactly one cycle.
- After clear, 16 consecutive plots covering a 4x4 block at (81,96) → 16 back-to-back writes in order, starting at addr 30801. oDropCount stays 0.
- Plot (320,10) and (5,240) → no writes, oDropCount=2. Force 300 rejected plots → oDropCount holds at 255.
- During CLEAR, 6 consecutive plots with FIFO_DEPTH=4 → the first 4 are accepted and oReady falls. 2 are dropped (oDropCount=2). The 4 pixels are written in order right after the sweep ends.
- With 3 pixels pending in CLEAR, pulse iClear → FIFO empties, the sweep restarts at addr 0, the pending pixels are never written, and oDropCount is unchanged.
